bsg_and_reduce_stream: RTL and testbench



---
 rtl/bsg_and_reduce_stream_pkg.sv | 18 +
 rtl/bsg_and_reduce_stream_and.sv | 13 +
 rtl/bsg_and_reduce_stream.sv | 118 +++++++++++
 tb/tb_bsg_and_reduce_stream.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bsg_and_reduce_stream_pkg.sv
// Shared types and helpers for the streaming AND-reduce block.
package bsg_and_reduce_stream_pkg;

   // Group FSM: collecting words, or holding a finished result for the consumer.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2
   } state_e;

   // Width of a counter that must hold 0..els inclusive; never narrower than 1 bit.
   function automatic int unsigned count_width(input int unsigned els);
      int unsigned w;
      w = $clog2(els + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/bsg_and_reduce_stream_and.sv
// Plain bitwise AND of two equal-width words; the fold step of the reducer.
module bsg_and_reduce_stream_and #(
   parameter int unsigned width_p = 16
) (
   input  logic [width_p-1:0] a,
   input  logic [width_p-1:0] b,
   output logic [width_p-1:0] and_c
);

   // Pure combinational AND.
   assign and_c = a & b;

endmodule

// File: rtl/bsg_and_reduce_stream.sv
// Folds a ready/valid stream of words into one bitwise-AND result per group
// and presents each result on a valid/yumi output.
module bsg_and_reduce_stream
   import bsg_and_reduce_stream_pkg::*;
#(
   parameter  int unsigned width_p    = 16,
   parameter  int unsigned els_p      = 4,
   localparam int unsigned count_w_lp = count_width(els_p)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  v_i,
   input  logic [width_p-1:0]    data_i,
   input  logic                  last_i,
   output logic                  ready_o,
   output logic                  v_o,
   output logic [width_p-1:0]    data_o,
   output logic [count_w_lp-1:0] count_o,
   output logic                  zero_o,
   input  logic                  yumi_i
);

   state_e                  state, state_n;
   logic [width_p-1:0]      acc, acc_n;
   logic [count_w_lp-1:0]   count, count_n;
   logic                    zero, zero_n;
   logic                    ready, ready_n;
   logic                    valid, valid_n;
   logic [width_p-1:0]      fold_c;
   logic [count_w_lp-1:0]   count_inc_c;
   logic                    accept_c;
   logic                    closing_c;

   // AND of the running accumulator with the incoming word.
   bsg_and_reduce_stream_and #(
      .width_p (width_p)
   ) fold (
      .a     (acc),
      .b     (data_i),
      .and_c (fold_c)
   );

   // Handshake and group-close qualifiers; ready is a flop so no path from v_i/yumi_i.
   assign accept_c    = v_i & ready;
   assign count_inc_c = count_w_lp'(count + count_w_lp'(1));
   assign closing_c   = last_i | (count_inc_c == count_w_lp'(els_p));

   // State register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state, next accumulator/count and next output flag values.
   always_comb begin
      state_n = state;
      acc_n   = acc;
      count_n = count;
      zero_n  = zero;
      unique case (state)
         IDLE, ACCUM: begin
            if (accept_c) begin
               acc_n   = fold_c;
               count_n = count_inc_c;
               if (closing_c) begin
                  state_n = EMIT;
                  zero_n  = (fold_c == '0);
               end else begin
                  state_n = ACCUM;
               end
            end
         end
         EMIT: begin
            if (yumi_i) begin
               state_n = IDLE;
               acc_n   = '1;
               count_n = '0;
               zero_n  = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            acc_n   = '1;
            count_n = '0;
            zero_n  = 1'b0;
         end
      endcase
      ready_n = (state_n != EMIT);
      valid_n = (state_n == EMIT);
   end

   // Datapath and output registers; reset discards any partial or held result.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         acc   <= '1;
         count <= '0;
         zero  <= 1'b0;
         ready <= 1'b0;
         valid <= 1'b0;
      end else begin
         acc   <= acc_n;
         count <= count_n;
         zero  <= zero_n;
         ready <= ready_n;
         valid <= valid_n;
      end
   end

   assign ready_o = ready;
   assign v_o     = valid;
   assign data_o  = acc;
   assign count_o = count;
   assign zero_o  = zero;

endmodule

// File: tb/tb_bsg_and_reduce_stream.sv
// Scoreboard bench for the streaming AND-reduce block (els_p=4 and els_p=1 builds).
module tb_bsg_and_reduce_stream;

   localparam int unsigned W   = 16;
   localparam int unsigned ELS = 4;

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  count;
      logic        zero;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          v_i, last_i, yumi_i;
   logic [W-1:0]  data_i;
   logic          ready_o, v_o, zero_o;
   logic [W-1:0]  data_o;
   logic [2:0]    count_o;

   logic          v1_i, last1_i, yumi1_i;
   logic [W-1:0]  data1_i;
   logic          ready1_o, v1_o, zero1_o;
   logic [W-1:0]  data1_o;
   logic [0:0]    count1_o;

   int vectors = 0;
   int miscompares = 0;

   exp_t          sb[$];
   logic [W-1:0]  m_acc;
   int            m_cnt;
   logic          m_ready, m_v;

   always #5 clk = ~clk;

   bsg_and_reduce_stream #(.width_p(W), .els_p(ELS)) dut (
      .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .last_i(last_i),
      .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .count_o(count_o),
      .zero_o(zero_o), .yumi_i(yumi_i));

   bsg_and_reduce_stream #(.width_p(W), .els_p(1)) dut1 (
      .clk_i(clk), .reset_i(reset_i), .v_i(v1_i), .data_i(data1_i), .last_i(last1_i),
      .ready_o(ready1_o), .v_o(v1_o), .data_o(data1_o), .count_o(count1_o),
      .zero_o(zero1_o), .yumi_i(yumi1_i));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle on the els_p=4 DUT: drive at negedge, check, model the edge, return at next negedge.
   task automatic cyc(input logic v, input logic [W-1:0] d, input logic l, input logic y);
      logic acc_ok, take;
      exp_t e;
      v_i = v; data_i = d; last_i = l; yumi_i = y && m_v;
      check("ready", 32'(ready_o), 32'(m_ready));
      check("valid", 32'(v_o), 32'(m_v));
      if (m_v) begin
         if (sb.size() == 0) begin
            check("sb_nonempty", 32'(0), 32'(1));
         end else begin
            check("data",  32'(data_o),  32'(sb[0].data));
            check("count", 32'(count_o), 32'(sb[0].count));
            check("zero",  32'(zero_o),  32'(sb[0].zero));
         end
      end
      acc_ok = v && m_ready;
      take   = y && m_v;
      @(posedge clk);
      if (take && sb.size() != 0) void'(sb.pop_front());
      if (take) m_v = 1'b0;
      if (acc_ok) begin
         m_acc = m_acc & d;
         m_cnt++;
         if (l || m_cnt == ELS) begin
            e.data  = m_acc;
            e.count = 3'(m_cnt);
            e.zero  = (m_acc == '0);
            sb.push_back(e);
            m_acc = '1;
            m_cnt = 0;
            m_v   = 1'b1;
         end
      end
      m_ready = !m_v;
      @(negedge clk);
   endtask

   task automatic model_reset();
      sb.delete();
      m_acc = '1; m_cnt = 0; m_ready = 1'b0; m_v = 1'b0;
   endtask

   initial begin
      reset_i = 1'b1;
      v_i = 0; data_i = '0; last_i = 0; yumi_i = 0;
      v1_i = 0; data1_i = '0; last1_i = 0; yumi1_i = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready_o), 32'(0));
      check("rst_valid", 32'(v_o), 32'(0));
      check("rst_data",  32'(data_o), 32'h0000_FFFF);
      check("rst_count", 32'(count_o), 32'(0));
      check("rst_zero",  32'(zero_o), 32'(0));
      reset_i = 1'b0;
      cyc(0, '0, 0, 0);

      // Full group back-to-back, then hold in EMIT before yumi.
      cyc(1, 16'hFFFF, 0, 0);
      cyc(1, 16'hF0F0, 0, 0);
      cyc(1, 16'hFF00, 0, 0);
      cyc(1, 16'hF3FF, 0, 0);
      cyc(0, '0, 0, 0);
      cyc(0, '0, 0, 0);
      cyc(0, '0, 0, 1);

      // Early close, then a fresh single-word group.
      cyc(1, 16'h00FF, 0, 0);
      cyc(1, 16'h0F0F, 1, 0);
      cyc(0, '0, 0, 1);
      cyc(1, 16'h1234, 1, 0);
      cyc(0, '0, 0, 1);

      // Zero result held under backpressure with a pending word.
      cyc(1, 16'hAAAA, 0, 0);
      cyc(1, 16'h5555, 1, 0);
      repeat (5) cyc(1, 16'hBEEF, 0, 0);
      cyc(0, '0, 0, 1);

      // Continuous valid with yumi in EMIT: the word waits for IDLE.
      cyc(1, 16'h0001, 1, 0);
      cyc(1, 16'h0001, 1, 1);
      cyc(1, 16'h0001, 1, 0);
      cyc(0, '0, 0, 1);

      // Last arriving on the els_p-th word closes once.
      cyc(1, 16'h0FF0, 0, 0);
      cyc(1, 16'h0FF0, 0, 0);
      cyc(1, 16'h00F0, 0, 0);
      cyc(1, 16'h0FFF, 1, 0);
      cyc(0, '0, 0, 0);
      cyc(0, '0, 0, 1);

      // Async reset between edges mid-group.
      cyc(1, 16'h0000, 0, 0);
      cyc(1, 16'h0000, 0, 0);
      v_i = 0;
      #2 reset_i = 1'b1;
      #1;
      check("amid_ready", 32'(ready_o), 32'(0));
      check("amid_valid", 32'(v_o), 32'(0));
      check("amid_count", 32'(count_o), 32'(0));
      check("amid_data",  32'(data_o), 32'h0000_FFFF);
      @(negedge clk);
      reset_i = 1'b0;
      model_reset();
      cyc(0, '0, 0, 0);
      repeat (4) cyc(1, 16'h8001, 0, 0);
      cyc(0, '0, 0, 1);

      // Random traffic.
      for (int i = 0; i < 200; i++) begin
         logic [W-1:0] d;
         d = 16'($urandom) | 16'($urandom);
         cyc(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 2) == 0));
      end
      for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1);

      // els_p=1 build: each word emits directly.
      begin
         logic [W-1:0] words [4];
         words[0] = 16'hCAFE; words[1] = 16'h0000; words[2] = 16'hFFFF; words[3] = 16'h1357;
         for (int k = 0; k < 4; k++) begin
            int waited;
            waited = 0;
            while (!ready1_o && waited < 10) begin @(negedge clk); waited++; end
            check("e1_ready", 32'(ready1_o), 32'(1));
            v1_i = 1'b1; data1_i = words[k]; last1_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            v1_i = 1'b0;
            check("e1_valid", 32'(v1_o), 32'(1));
            check("e1_ready_emit", 32'(ready1_o), 32'(0));
            check("e1_data",  32'(data1_o), 32'(words[k]));
            check("e1_count", 32'(count1_o), 32'(1));
            check("e1_zero",  32'(zero1_o), 32'(words[k] == '0));
            yumi1_i = 1'b1;
            @(negedge clk);
            yumi1_i = 1'b0;
            check("e1_valid_drop", 32'(v1_o), 32'(0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

endmodule
